// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the pipelined MIPS core.
//
// Serves the core's M-stage data request interface. Reads are combinational.
// Writes honour per-byte enables and commit at the clock edge. Every
// committed store produces a registered one-cycle trace (t_*) that mirrors
// the core's w_grf_* trace. Any cycle whose address is out of range latches
// a sticky error and the offending address.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          synchronous active-high reset (clears memory too)
//   m_data_addr    byte address from M stage; bits [1:0] ignored for indexing
//   m_data_wdata   lane-aligned write data
//   m_data_byteen  byte write enables; 4'b0000 = read or idle
//   m_inst_addr    PC of the instruction in M (trace only)
//   m_data_rdata   combinational read of the addressed word (0 when out of range)
//   t_valid        one-cycle pulse the cycle after a committed write
//   t_pc           PC of the committed store
//   t_addr         word-aligned byte address of the committed store
//   t_data         merged word after the store
//   wr_count       committed writes since reset (wraps)
//   err_sticky     set on the first out-of-range access
//   err_addr       address of the first out-of-range access
//
// Optional feature macro: DM_TRACE_DISPLAY_EN
//   When defined, each committed write prints "@<pc>: *<addr> <= <data>"
//   in the cycle t_valid is asserted.

module dm_responder #(
    parameter int unsigned DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned AW        = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        t_valid,
    output logic [31:0] t_pc,
    output logic [31:0] t_addr,
    output logic [31:0] t_data,
    output logic [31:0] wr_count,
    output logic        err_sticky,
    output logic [31:0] err_addr
);

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [31:0] idx_full;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        do_write;
    logic [31:0] old_word;
    logic [31:0] merged;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to a huge index and
    // fail the DEPTH bound; the explicit >= check covers that case as well.
    always_comb begin
        offset   = m_data_addr - BASE_ADDR;
        idx_full = offset >> 2;
        idx      = idx_full[AW-1:0];
        in_range = (m_data_addr >= BASE_ADDR) && (idx_full < DEPTH);
        do_write = in_range && (m_data_byteen != 4'b0000);
    end

    always_comb begin
        old_word = in_range ? mem[idx] : 32'h0;
        merged   = old_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    // No write-through bypass: a same-cycle read sees the pre-write word.
    assign m_data_rdata = old_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= 32'h0;
            end
            t_valid    <= 1'b0;
            t_pc       <= 32'h0;
            t_addr     <= 32'h0;
            t_data     <= 32'h0;
            wr_count   <= 32'h0;
            err_sticky <= 1'b0;
            err_addr   <= 32'h0;
        end else begin
            t_valid <= 1'b0;
            if (do_write) begin
                mem[idx] <= merged;
                t_valid  <= 1'b1;
                t_pc     <= m_inst_addr;
                t_addr   <= {m_data_addr[31:2], 2'b00};
                t_data   <= merged;
                wr_count <= wr_count + 32'd1;
            end
            // Idle cycles count too: the core always drives an address.
            if (!in_range && !err_sticky) begin
                err_sticky <= 1'b1;
                err_addr   <= m_data_addr;
            end
        end
    end

`ifdef DM_TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (t_valid) begin
            $display("@%h: *%h <= %h", t_pc, t_addr, t_data);
        end
    end
`else
    // Trace printing disabled; ports and logic are unchanged.
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int unsigned DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m_data_addr = 32'h10;
    logic [31:0] m_data_wdata = 32'h0;
    logic [3:0]  m_data_byteen = 4'h0;
    logic [31:0] m_inst_addr = 32'h0;
    logic [31:0] m_data_rdata;
    logic        t_valid;
    logic [31:0] t_pc, t_addr, t_data, wr_count, err_addr;
    logic        err_sticky;

    dm_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .AW(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .t_valid      (t_valid),
        .t_pc         (t_pc),
        .t_addr       (t_addr),
        .t_data       (t_data),
        .wr_count     (wr_count),
        .err_sticky   (err_sticky),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array plus the architectural trace/status values.
    logic [31:0] mdl_mem [DEPTH];
    logic        mdl_tv;
    logic [31:0] mdl_tpc, mdl_taddr, mdl_tdata, mdl_cnt, mdl_eaddr;
    logic        mdl_err;
    bit          started = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
            mdl_tv = 0; mdl_tpc = 0; mdl_taddr = 0; mdl_tdata = 0;
            mdl_cnt = 0; mdl_err = 0; mdl_eaddr = 0;
            started = 1;
        end else begin
            mdl_tv = 0;
            if (!addr_ok(m_data_addr)) begin
                if (!mdl_err) begin
                    mdl_err   = 1;
                    mdl_eaddr = m_data_addr;
                end
            end else if (m_data_byteen != 4'h0) begin
                w = mdl_mem[word_of(m_data_addr)];
                for (int b = 0; b < 4; b++)
                    if (m_data_byteen[b]) w[8*b +: 8] = m_data_wdata[8*b +: 8];
                mdl_mem[word_of(m_data_addr)] = w;
                mdl_tv    = 1;
                mdl_tpc   = m_inst_addr;
                mdl_taddr = m_data_addr & ~32'h3;
                mdl_tdata = w;
                mdl_cnt   = mdl_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_rdata", m_data_rdata,
                addr_ok(m_data_addr) ? mdl_mem[word_of(m_data_addr)] : 32'h0);
            chk("cmp_t_valid", {31'h0, t_valid}, {31'h0, mdl_tv});
            chk("cmp_t_pc", t_pc, mdl_tpc);
            chk("cmp_t_addr", t_addr, mdl_taddr);
            chk("cmp_t_data", t_data, mdl_tdata);
            chk("cmp_wr_count", wr_count, mdl_cnt);
            chk("cmp_err_sticky", {31'h0, err_sticky}, {31'h0, mdl_err});
            chk("cmp_err_addr", err_addr, mdl_eaddr);
        end
    end

    // Apply one cycle's inputs just after the posedge, return at the negedge.
    task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] pc);
        @(posedge clk);
        #1;
        reset = rst; m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
        @(negedge clk);
    endtask

    initial begin
        drive(1, 32'h10, 0, 4'h0, 0);
        drive(1, 32'h10, 0, 4'h0, 0);
        drive(0, 32'h10, 0, 4'h0, 0);
        chk("reset_rdata", m_data_rdata, 32'h0);
        chk("reset_t_valid", {31'h0, t_valid}, 32'h0);
        chk("reset_wr_count", wr_count, 32'h0);
        chk("reset_err", {31'h0, err_sticky}, 32'h0);

        drive(0, 32'h10, 32'hAABBCCDD, 4'hF, 32'h3000);
        chk("w1_same_cycle_rdata", m_data_rdata, 32'h0);
        drive(0, 32'h12, 32'h1122_0000, 4'hC, 32'h3004);
        chk("w1_t_valid", {31'h0, t_valid}, 32'h1);
        chk("w1_t_pc", t_pc, 32'h3000);
        chk("w1_t_addr", t_addr, 32'h10);
        chk("w1_t_data", t_data, 32'hAABBCCDD);
        chk("w1_rdata", m_data_rdata, 32'hAABBCCDD);
        chk("w1_wr_count", wr_count, 32'd1);

        drive(0, 32'h11, 32'h0000_EE00, 4'h2, 32'h3008);
        chk("w2_t_addr", t_addr, 32'h10);
        chk("w2_t_data", t_data, 32'h1122CCDD);
        chk("w2_rdata", m_data_rdata, 32'h1122CCDD);

        drive(0, 32'h20, 32'h5, 4'hF, 32'h300C);
        chk("w3_t_data", t_data, 32'h1122EEDD);
        chk("w4_same_cycle_rdata", m_data_rdata, 32'h0);
        drive(0, 32'h20, 0, 4'h0, 0);
        chk("w4_next_rdata", m_data_rdata, 32'h5);
        chk("w4_wr_count", wr_count, 32'd4);
        drive(0, 32'h10, 0, 4'h0, 0);
        chk("idle_t_valid", {31'h0, t_valid}, 32'h0);
        chk("idle_t_data_hold", t_data, 32'h5);
        chk("read_merged", m_data_rdata, 32'h1122EEDD);

        drive(0, 32'h3000, 32'hDEADBEEF, 4'hF, 32'h3010);
        chk("oor_rdata", m_data_rdata, 32'h0);
        drive(0, 32'h4000, 0, 4'h0, 0);
        chk("oor_no_trace", {31'h0, t_valid}, 32'h0);
        chk("oor_wr_count", wr_count, 32'd4);
        chk("oor_err_sticky", {31'h0, err_sticky}, 32'h1);
        chk("oor_err_addr", err_addr, 32'h3000);
        drive(0, 32'h10, 0, 4'h0, 0);
        chk("oor2_err_addr", err_addr, 32'h3000);

        drive(0, 32'h2FFC, 32'h1234_5678, 4'hF, 32'h3014);
        drive(0, 32'h2FFC, 0, 4'h0, 0);
        chk("last_word_t_addr", t_addr, 32'h2FFC);
        chk("last_word_rdata", m_data_rdata, 32'h1234_5678);
        chk("last_word_wr_count", wr_count, 32'd5);

        drive(1, 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h3020);
        drive(0, 32'h10, 0, 4'h0, 0);
        chk("rst_wr_rdata", m_data_rdata, 32'h0);
        chk("rst_wr_t_valid", {31'h0, t_valid}, 32'h0);
        chk("rst_wr_t_pc", t_pc, 32'h0);
        chk("rst_wr_t_addr", t_addr, 32'h0);
        chk("rst_wr_t_data", t_data, 32'h0);
        chk("rst_wr_wr_count", wr_count, 32'h0);
        chk("rst_wr_err_sticky", {31'h0, err_sticky}, 32'h0);
        chk("rst_wr_err_addr", err_addr, 32'h0);

        drive(0, 32'h24, 32'h0077_0000, 4'h4, 32'h3024);
        drive(0, 32'h24, 0, 4'h0, 0);
        chk("post_rst_byte_rdata", m_data_rdata, 32'h0077_0000);
        chk("post_rst_wr_count", wr_count, 32'd1);
        drive(0, 32'h10, 0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
